// File: rtl/exec_pipe_pkg.sv
// exec_pipe_pkg: shared opcodes and FSM state for the exec_pipe ALU stage
package exec_pipe_pkg;
    localparam logic [3:0] OP_OR   = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_RSV4 = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_LT   = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_GT   = 4'b1000;
    localparam logic [3:0] OP_ANDN = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_XNOR = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_NE   = 4'b1110;
    localparam logic [3:0] OP_RSVF = 4'b1111;
    typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/exec_pipe_mul.sv
// mul_iter: iterative shift-add multiplier, MUL_STEP bits of b per edge, low WIDTH bits of a*b
// ports: clk, reset_n (sync active-low), start (load a/b and do first step), a, b,
//        product (running sum including the current step), done (product is final this cycle)
module mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done
);
    localparam int N  = WIDTH / MUL_STEP;
    localparam int CW = $clog2(N + 1);
    logic [WIDTH-1:0] acc, a_sh, b_sh, src_a, src_b;
    logic [CW-1:0]    cnt;
    // the start edge already consumes the first chunk, so cnt holds steps still to go
    assign src_a   = start ? a : a_sh;
    assign src_b   = start ? b : b_sh;
    assign product = (start ? '0 : acc) + src_a * WIDTH'(src_b[MUL_STEP-1:0]);
    assign done    = start ? (N == 1) : (cnt == CW'(1));
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
        end else if (start || cnt != '0) begin
            acc  <= product;
            a_sh <= src_a << MUL_STEP;
            b_sh <= src_b >> MUL_STEP;
            cnt  <= start ? CW'(N - 1) : cnt - CW'(1);
        end
    end
endmodule

// File: rtl/exec_pipe.sv
// exec_pipe: handshaked tenyr ALU stage, rhs = f(X, O) + A with iterative multiply
// ports: clk, reset_n (sync active-low); in_valid/in_ready, op, swap, X, Y, I (operation in);
//        out_valid/out_ready, rhs, illegal (result out, illegal marks reserved opcodes)
module exec_pipe
    import exec_pipe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             swap,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] I,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rhs,
    output logic             illegal
);
    state_t           state;
    logic [WIDTH-1:0] o_sel, a_sel, a_mul, f, product;
    logic             accept, is_mul, rsv, mul_done, lt, gt;
    assign in_ready = reset_n && state == S_IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign o_sel    = swap ? I : Y;
    assign a_sel    = swap ? Y : I;
    assign is_mul   = op == OP_MUL;
    assign rsv      = op == OP_RSV4 || op == OP_RSVF;
    assign lt       = $signed(X) < $signed(o_sel);
    assign gt       = $signed(X) > $signed(o_sel);
    // reserved opcodes leave f at zero so rhs degenerates to A
    always_comb begin
        f = '0;
        case (op)
            OP_OR:   f = X | o_sel;
            OP_AND:  f = X & o_sel;
            OP_ADD:  f = X + o_sel;
            OP_SLL:  f = o_sel >= WIDTH'(WIDTH) ? '0 : X << o_sel;
            OP_LT:   f = {WIDTH{lt}};
            OP_EQ:   f = {WIDTH{X == o_sel}};
            OP_GT:   f = {WIDTH{gt}};
            OP_ANDN: f = X & ~o_sel;
            OP_XOR:  f = X ^ o_sel;
            OP_SUB:  f = X - o_sel;
            OP_XNOR: f = ~(X ^ o_sel);
            OP_SRL:  f = o_sel >= WIDTH'(WIDTH) ? '0 : X >> o_sel;
            OP_NE:   f = {WIDTH{X != o_sel}};
            default: f = '0;
        endcase
    end
    mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && is_mul),
        .a       (X),
        .b       (o_sel),
        .product (product),
        .done    (mul_done)
    );
    // a drain clears out_valid unless a fresh result lands on the same edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            rhs       <= '0;
            illegal   <= 1'b0;
            a_mul     <= '0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (state == S_MUL) begin
                if (mul_done) begin
                    state     <= S_IDLE;
                    rhs       <= product + a_mul;
                    illegal   <= 1'b0;
                    out_valid <= 1'b1;
                end
            end else if (accept) begin
                if (is_mul && !mul_done) begin
                    state <= S_MUL;
                    a_mul <= a_sel;
                end else begin
                    rhs       <= (is_mul ? product : f) + a_sel;
                    illegal   <= rsv;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_pipe.sv
// tb_exec_pipe: random and directed stimulus checked against a behavioural model of exec_pipe
module tb_exec_pipe;
    import exec_pipe_pkg::*;
    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         swap = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic [W-1:0] I = '0;
    logic         in_ready, out_valid, illegal;
    logic [W-1:0] rhs;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    bit           pv = 0;
    bit           pill = 0;
    logic [W-1:0] prhs = '0;
    int           pat = 0;

    always #5 clk = ~clk;

    exec_pipe #(.WIDTH(W), .MUL_STEP(S)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .swap      (swap),
        .X         (X),
        .Y         (Y),
        .I         (I),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rhs       (rhs),
        .illegal   (illegal)
    );

    function automatic logic [W:0] ref_op(logic [3:0] o, logic sw, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] i);
        logic [W-1:0] ov, av, fv;
        logic [63:0]  p;
        logic         il;
        ov = sw ? i : y;
        av = sw ? y : i;
        il = 1'b0;
        p  = 64'(x) * 64'(ov);
        case (o)
            OP_OR:   fv = x | ov;
            OP_AND:  fv = x & ov;
            OP_ADD:  fv = x + ov;
            OP_MUL:  fv = p[W-1:0];
            OP_SLL:  fv = (ov >= 32'd32) ? '0 : x << ov[4:0];
            OP_LT:   fv = ($signed(x) < $signed(ov)) ? '1 : '0;
            OP_EQ:   fv = (x == ov) ? '1 : '0;
            OP_GT:   fv = ($signed(x) > $signed(ov)) ? '1 : '0;
            OP_ANDN: fv = x & ~ov;
            OP_XOR:  fv = x ^ ov;
            OP_SUB:  fv = x - ov;
            OP_XNOR: fv = ~(x ^ ov);
            OP_SRL:  fv = (ov >= 32'd32) ? '0 : x >> ov[4:0];
            OP_NE:   fv = (x != ov) ? '1 : '0;
            default: begin fv = '0; il = 1'b1; end
        endcase
        return {il, fv + av};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // one cycle: drive inputs after negedge, compare the pre-edge view, advance the model
    task automatic step(input bit v, input logic [3:0] o, input bit sw, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] i, input bit ordy, input bit rst);
        bit           eov, eir;
        logic [W:0]   r;
        @(negedge clk);
        reset_n = rst; in_valid = v; op = o; swap = sw; X = x; Y = y; I = i; out_ready = ordy;
        #1;
        eov = pv && cyc >= pat;
        eir = rst && !(pv && cyc < pat) && (!eov || ordy);
        chk("in_ready", W'(in_ready), W'(eir));
        chk("out_valid", W'(out_valid), W'(eov));
        if (eov) begin
            chk("rhs", rhs, prhs);
            chk("illegal", W'(illegal), W'(pill));
        end
        if (!rst) pv = 0;
        else begin
            if (eov && ordy) pv = 0;
            if (v && eir) begin
                r    = ref_op(o, sw, x, y, i);
                pv   = 1;
                prhs = r[W-1:0];
                pill = r[W];
                pat  = cyc + ((o == OP_MUL) ? N : 1);
            end
        end
        cyc++;
    endtask

    task automatic idle(input bit ordy);
        step(0, OP_OR, 0, '0, '0, '0, ordy, 1);
    endtask

    initial begin
        step(0, OP_OR, 0, '0, '0, '0, 0, 0);
        step(1, OP_ADD, 0, 1, 2, 3, 0, 0);
        chk("reset rhs", rhs, '0);
        chk("reset illegal", W'(illegal), '0);
        chk("reset in_ready", W'(in_ready), '0);
        idle(1);
        chk("ready after reset", W'(in_ready), 32'd1);

        step(1, OP_ADD, 0, 5, 7, 3, 1, 1);
        idle(0);
        chk("add rhs", rhs, 32'd15);
        chk("add valid", W'(out_valid), 32'd1);
        chk("add illegal", W'(illegal), '0);
        for (int k = 0; k < 3; k++) begin
            step(1, OP_SUB, 0, 20, 8, 1, 0, 1);
            chk("hold rhs", rhs, 32'd15);
            chk("hold ready", W'(in_ready), '0);
        end
        step(1, OP_SUB, 0, 20, 8, 1, 1, 1);
        chk("drain+accept ready", W'(in_ready), 32'd1);
        idle(1);
        chk("sub rhs", rhs, 32'd13);

        step(1, OP_LT, 1, 32'hFFFF_FFFF, 10, 0, 1, 1);
        idle(1);
        chk("swap lt rhs", rhs, 32'd9);

        step(1, OP_MUL, 0, 32'h0001_0001, 32'h0001_0001, 0, 1, 1);
        for (int k = 0; k < N - 1; k++) begin
            idle(1);
            chk("mul busy ready", W'(in_ready), '0);
            chk("mul busy valid", W'(out_valid), '0);
        end
        idle(1);
        chk("mul rhs", rhs, 32'h0002_0001);
        chk("mul valid", W'(out_valid), 32'd1);

        step(1, OP_SLL, 0, 1, 32, 4, 1, 1);
        idle(1);
        chk("sll big rhs", rhs, 32'd4);
        step(1, OP_RSV4, 0, 1, 5, 9, 1, 1);
        idle(1);
        chk("rsv rhs", rhs, 32'd9);
        chk("rsv illegal", W'(illegal), 32'd1);

        step(1, OP_MUL, 0, 3, 4, 0, 1, 1);
        idle(1);
        step(0, OP_OR, 0, '0, '0, '0, 1, 0);
        idle(1);
        chk("post-reset ready", W'(in_ready), 32'd1);
        for (int k = 0; k < N + 2; k++) begin
            idle(1);
            chk("aborted mul valid", W'(out_valid), '0);
        end

        for (int n = 0; n < 4000; n++) begin
            logic [W-1:0] x, y, i;
            x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            y = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            i = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            if ($urandom_range(0, 7) == 0) y = x;
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 x, y, i, $urandom_range(0, 9) < 6, $urandom_range(0, 99) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
